// File: rtl/agendador_medida_dht11.sv
// Periodic DHT11 read scheduler: fires medir every PERIODO cycles while ligar is set, keeps the
// last good reading, counts consecutive failed reads and flags a dead sensor.
module agendador_medida_dht11 #(
    parameter int PERIODO      = 100_000_000,
    parameter int TIMEOUT_RESP = 75_000_000,
    parameter int MAX_ERROS    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        pronto,
    input  logic        erro,
    input  logic [15:0] temperatura_in,
    input  logic [15:0] umidade_in,
    output logic        medir,
    output logic [15:0] temperatura,
    output logic [15:0] umidade,
    output logic        nova_medida,
    output logic        falha_sensor,
    output logic [2:0]  db_estado
);

    localparam int PW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int TW = (TIMEOUT_RESP > 1) ? $clog2(TIMEOUT_RESP) : 1;
    localparam int EW = $clog2(MAX_ERROS + 1);

    typedef enum logic [2:0] {
        INICIAL    = 3'd0,
        DISPARA    = 3'd1,
        AGUARDA    = 3'd2,
        REGISTRA   = 3'd3,
        CONTA_ERRO = 3'd4,
        ESPERA     = 3'd5
    } estado_t;

    estado_t        estado, estado_next;
    logic [PW-1:0]  cnt_periodo;
    logic [TW-1:0]  cnt_timeout;
    logic [EW-1:0]  cnt_erros;
    logic [15:0]    temp_buf, umid_buf;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIAL;
        else        estado <= estado_next;
    end

    always_comb begin
        estado_next = estado;
        case (estado)
            INICIAL:    if (ligar) estado_next = DISPARA;
            DISPARA:    estado_next = AGUARDA;
            AGUARDA: begin
                // erro wins over pronto: a simultaneous pair is a failed read
                if (erro)                                       estado_next = CONTA_ERRO;
                else if (pronto)                                estado_next = REGISTRA;
                else if (cnt_timeout == TW'(TIMEOUT_RESP - 1))  estado_next = CONTA_ERRO;
            end
            REGISTRA, CONTA_ERRO: estado_next = ESPERA;
            ESPERA: begin
                if (!ligar)                                 estado_next = INICIAL;
                else if (cnt_periodo == PW'(PERIODO - 1))   estado_next = DISPARA;
            end
            default:    estado_next = INICIAL;
        endcase
    end

    // Period counter reads 0 during the DISPARA cycle, so pulses land exactly PERIODO apart
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                       cnt_periodo <= '0;
        else if (estado_next == DISPARA)  cnt_periodo <= '0;
        else if (estado != INICIAL)       cnt_periodo <= cnt_periodo + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                   cnt_timeout <= '0;
        else if (estado == DISPARA)   cnt_timeout <= '0;
        else if (estado == AGUARDA)   cnt_timeout <= cnt_timeout + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            temp_buf     <= '0;
            umid_buf     <= '0;
            temperatura  <= '0;
            umidade      <= '0;
            cnt_erros    <= '0;
            falha_sensor <= 1'b0;
        end else begin
            if (estado == AGUARDA && pronto && !erro) begin
                temp_buf <= temperatura_in;
                umid_buf <= umidade_in;
            end
            if (estado == REGISTRA) begin
                temperatura  <= temp_buf;
                umidade      <= umid_buf;
                cnt_erros    <= '0;
                falha_sensor <= 1'b0;
            end
            if (estado == CONTA_ERRO) begin
                if (cnt_erros < EW'(MAX_ERROS))
                    cnt_erros <= cnt_erros + 1'b1;
                if (cnt_erros >= EW'(MAX_ERROS - 1))
                    falha_sensor <= 1'b1;
            end
        end
    end

    assign medir       = (estado == DISPARA);
    assign nova_medida = (estado == REGISTRA);
    assign db_estado   = estado;

endmodule

// File: tb/tb_agendador_medida_dht11.sv
// Directed bench for agendador_medida_dht11 with a scripted medir_dht11 responder.
module tb_agendador_medida_dht11;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ligar = 1'b0;
    logic        pronto = 1'b0;
    logic        erro = 1'b0;
    logic [15:0] temperatura_in = '0;
    logic [15:0] umidade_in = '0;
    logic        medir, nova_medida, falha_sensor;
    logic [15:0] temperatura, umidade;
    logic [2:0]  db_estado;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    agendador_medida_dht11 #(.PERIODO(20), .TIMEOUT_RESP(10), .MAX_ERROS(3)) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .pronto(pronto), .erro(erro),
        .temperatura_in(temperatura_in), .umidade_in(umidade_in),
        .medir(medir), .temperatura(temperatura), .umidade(umidade),
        .nova_medida(nova_medida), .falha_sensor(falha_sensor), .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_medir(output int at);
        int n;
        n = 0;
        while (medir !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        if (medir !== 1'b1) chk("medir_timeout", 32'(medir), 32'd1);
        at = cyc;
    endtask

    // Called in the medir cycle; answers pronto 'dly' cycles later
    task automatic read_ok(input logic [15:0] t, input logic [15:0] u, input int dly);
        repeat (dly) tick;
        pronto = 1'b1; temperatura_in = t; umidade_in = u;
        tick;
        pronto = 1'b0; temperatura_in = 16'hDEAD; umidade_in = 16'hBEEF;
        chk("nova_pulse", 32'(nova_medida), 32'd1);
        chk("estado_registra", 32'(db_estado), 32'd3);
        tick;
        chk("nova_single", 32'(nova_medida), 32'd0);
        chk("temperatura", 32'(temperatura), 32'(t));
        chk("umidade", 32'(umidade), 32'(u));
        chk("falha_clear", 32'(falha_sensor), 32'd0);
    endtask

    task automatic read_err(input int dly, input logic both, input logic falha_exp);
        repeat (dly) tick;
        erro = 1'b1; pronto = both; temperatura_in = 16'hAAAA; umidade_in = 16'h5555;
        tick;
        erro = 1'b0; pronto = 1'b0;
        chk("err_no_nova", 32'(nova_medida), 32'd0);
        chk("estado_conta_erro", 32'(db_estado), 32'd4);
        tick;
        chk("estado_espera", 32'(db_estado), 32'd5);
        chk("falha_sensor", 32'(falha_sensor), 32'(falha_exp));
        chk("temp_held", 32'(temperatura), 32'h1905);
        chk("umid_held", 32'(umidade), 32'h3C00);
    endtask

    initial begin
        int t0, t1, n, seen;
        repeat (3) tick;
        chk("rst_estado", 32'(db_estado), 32'd0);
        chk("rst_medir", 32'(medir), 32'd0);
        chk("rst_temp", 32'(temperatura), 32'd0);
        chk("rst_falha", 32'(falha_sensor), 32'd0);
        chk("rst_nova", 32'(nova_medida), 32'd0);
        reset = 1'b1;
        tick;

        // 1: immediate first read, then exact 20-cycle period
        ligar = 1'b1;
        tick;
        chk("first_medir", 32'(medir), 32'd1);
        wait_medir(t0);
        read_ok(16'h1905, 16'h3C00, 4);
        wait_medir(t1);
        chk("periodo_1", 32'(t1 - t0), 32'd20);
        read_ok(16'h1905, 16'h3C00, 4);
        wait_medir(t0);
        chk("periodo_2", 32'(t0 - t1), 32'd20);

        // 2: three failures in a row, then recovery
        read_err(3, 1'b0, 1'b0);
        wait_medir(t1);
        chk("periodo_err", 32'(t1 - t0), 32'd20);
        read_err(2, 1'b0, 1'b0);
        wait_medir(t0);
        read_err(5, 1'b0, 1'b1);
        wait_medir(t1);
        read_ok(16'h1905, 16'h3C00, 4);

        // 3: no answer -> 10 cycles in AGUARDA
        wait_medir(t0);
        tick;
        n = 0;
        while (db_estado == 3'd2 && n < 50) begin
            n++;
            tick;
        end
        chk("aguarda_len", 32'(n), 32'd10);
        chk("timeout_conta", 32'(db_estado), 32'd4);
        chk("timeout_nova", 32'(nova_medida), 32'd0);
        tick;
        chk("timeout_espera", 32'(db_estado), 32'd5);
        wait_medir(t1);
        chk("periodo_timeout", 32'(t1 - t0), 32'd20);

        // 4: pronto+erro together is a failure; a third failure raises falha_sensor
        read_err(3, 1'b1, 1'b0);
        wait_medir(t0);
        read_err(3, 1'b0, 1'b1);

        // 5: ligar drops mid-read, read completes, FSM parks in INICIAL
        wait_medir(t1);
        repeat (2) tick;
        ligar = 1'b0;
        repeat (2) tick;
        pronto = 1'b1; temperatura_in = 16'h2211; umidade_in = 16'h4433;
        tick;
        pronto = 1'b0;
        chk("off_nova", 32'(nova_medida), 32'd1);
        tick;
        chk("off_espera", 32'(db_estado), 32'd5);
        chk("off_temp", 32'(temperatura), 32'h2211);
        chk("off_umid", 32'(umidade), 32'h4433);
        chk("off_falha", 32'(falha_sensor), 32'd0);
        tick;
        chk("off_inicial", 32'(db_estado), 32'd0);
        seen = 0;
        repeat (30) begin
            tick;
            if (medir) seen++;
        end
        chk("off_no_medir", 32'(seen), 32'd0);
        ligar = 1'b1;
        tick;
        chk("relig_medir", 32'(medir), 32'd1);

        // 6: async reset mid-read
        tick;
        tick;
        chk("pre_rst_aguarda", 32'(db_estado), 32'd2);
        reset = 1'b0;
        #1;
        chk("arst_estado", 32'(db_estado), 32'd0);
        chk("arst_medir", 32'(medir), 32'd0);
        chk("arst_temp", 32'(temperatura), 32'd0);
        chk("arst_umid", 32'(umidade), 32'd0);
        ligar = 1'b0;
        pronto = 1'b1; temperatura_in = 16'h7777;
        tick;
        reset = 1'b1;
        tick;
        tick;
        pronto = 1'b0;
        chk("late_pronto_estado", 32'(db_estado), 32'd0);
        chk("late_pronto_nova", 32'(nova_medida), 32'd0);
        chk("late_pronto_temp", 32'(temperatura), 32'd0);
        chk("late_pronto_medir", 32'(medir), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
